// File: rtl/brdg_intrp_responder_pkg.sv
// Shared TLX interrupt encodings plus the drain FSM state and response record types.
package brdg_intrp_responder_pkg;

  localparam logic [7:0] OP_INTRP_REQ_LO = 8'h58;
  localparam logic [7:0] OP_INTRP_REQ_HI = 8'h5B;
  localparam logic [7:0] OP_INTRP_RESP   = 8'h0C;
  localparam logic [7:0] OP_INTRP_RDY    = 8'h1A;

  localparam logic [3:0] CODE_DONE          = 4'h0;
  localparam logic [3:0] CODE_RTY_REQ       = 4'h2;
  localparam logic [3:0] CODE_INTRP_PENDING = 4'h4;
  localparam logic [3:0] CODE_FAILED        = 4'hE;

  typedef enum logic {
    D_IDLE,
    D_ISSUE
  } drain_state_t;

  typedef struct packed {
    logic        valid;
    logic [7:0]  opcode;
    logic [15:0] afutag;
    logic [3:0]  code;
  } rsp_t;

  function automatic logic is_intrp_req(input logic [7:0] op);
    return (op >= OP_INTRP_REQ_LO) && (op <= OP_INTRP_REQ_HI);
  endfunction

endpackage

// File: rtl/brdg_intrp_responder_if.sv
// Command, response and host-sink signals of the interrupt responder, bundled as one interface.
interface brdg_intrp_responder_if;

  logic        cmd_valid;
  logic [7:0]  cmd_opcode;
  logic [15:0] cmd_afutag;
  logic [67:0] cmd_obj;
  logic        host_accept_en;
  logic        force_retry;
  logic        rsp_valid;
  logic [7:0]  rsp_opcode;
  logic [15:0] rsp_afutag;
  logic [3:0]  rsp_code;
  logic        host_int_valid;
  logic [63:0] host_int_src;
  logic        host_int_ready;

  modport master (
    output cmd_valid, cmd_opcode, cmd_afutag, cmd_obj,
    output host_accept_en, force_retry, host_int_ready,
    input  rsp_valid, rsp_opcode, rsp_afutag, rsp_code,
    input  host_int_valid, host_int_src
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_afutag, cmd_obj,
    input  host_accept_en, force_retry, host_int_ready,
    output rsp_valid, rsp_opcode, rsp_afutag, rsp_code,
    output host_int_valid, host_int_src
  );

endinterface

// File: rtl/brdg_intrp_pend_fifo.sv
// Pending-afutag FIFO: power-of-two depth, combinational head, simultaneous push/pop allowed.
module brdg_intrp_pend_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             push_ok, pop_ok;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign count_next = count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);

  // Head is read straight from the array so the drain FSM sees it the cycle it issues.
  assign head = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/brdg_intrp_responder.sv
// Host-side interrupt responder: decides intrp_resp for each intrp_req, holds one host slot,
// and drains pended afutags back to the requester as intrp_rdy.
module brdg_intrp_responder
  import brdg_intrp_responder_pkg::*;
#(
  parameter int PEND_DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  brdg_intrp_responder_if.slave bus
);

  logic         fifo_full, fifo_empty;
  logic [15:0]  fifo_head;
  logic         push, pop, load, slot_free, rdy_fire;
  drain_state_t state_reg, state_next;
  rsp_t         rsp_reg, rsp_next;
  logic         slot_valid_reg, slot_valid_next;
  logic [63:0]  slot_src_reg, slot_src_next;

  brdg_intrp_pend_fifo #(
    .DEPTH (PEND_DEPTH),
    .WIDTH (16)
  ) u_pend_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (bus.cmd_afutag),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Drain FSM: a command response always owns the port, so the rdy waits in D_ISSUE.
  always_comb begin
    state_next = state_reg;
    rdy_fire   = 1'b0;
    pop        = 1'b0;
    case (state_reg)
      D_IDLE: begin
        if (!fifo_empty && bus.host_accept_en && !slot_valid_reg) state_next = D_ISSUE;
      end
      D_ISSUE: begin
        if (!bus.cmd_valid) begin
          rdy_fire   = 1'b1;
          pop        = 1'b1;
          state_next = D_IDLE;
        end
      end
      default: state_next = D_IDLE;
    endcase
  end

  assign slot_free = !slot_valid_reg || bus.host_int_ready;

  always_comb begin
    rsp_next = '0;
    push     = 1'b0;
    load     = 1'b0;
    if (bus.cmd_valid) begin
      rsp_next.valid  = 1'b1;
      rsp_next.opcode = OP_INTRP_RESP;
      rsp_next.afutag = bus.cmd_afutag;
      if (!is_intrp_req(bus.cmd_opcode) || (bus.cmd_obj[67:64] != 4'h0)) begin
        rsp_next.code = CODE_FAILED;
      end else if (bus.force_retry) begin
        rsp_next.code = CODE_RTY_REQ;
      end else if (bus.host_accept_en && slot_free) begin
        rsp_next.code = CODE_DONE;
        load          = 1'b1;
      end else if (!fifo_full) begin
        rsp_next.code = CODE_INTRP_PENDING;
        push          = 1'b1;
      end else begin
        rsp_next.code = CODE_RTY_REQ;
      end
    end else if (rdy_fire) begin
      rsp_next.valid  = 1'b1;
      rsp_next.opcode = OP_INTRP_RDY;
      rsp_next.afutag = fifo_head;
      rsp_next.code   = bus.force_retry ? CODE_RTY_REQ : CODE_DONE;
    end
  end

  always_comb begin
    slot_valid_next = load || (slot_valid_reg && !bus.host_int_ready);
    slot_src_next   = load ? bus.cmd_obj[63:0] : slot_src_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= D_IDLE;
      rsp_reg        <= '0;
      slot_valid_reg <= 1'b0;
      slot_src_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      rsp_reg        <= rsp_next;
      slot_valid_reg <= slot_valid_next;
      slot_src_reg   <= slot_src_next;
    end
  end

  assign bus.rsp_valid      = rsp_reg.valid;
  assign bus.rsp_opcode     = rsp_reg.opcode;
  assign bus.rsp_afutag     = rsp_reg.afutag;
  assign bus.rsp_code       = rsp_reg.code;
  assign bus.host_int_valid = slot_valid_reg;
  assign bus.host_int_src   = slot_src_reg;

endmodule

// File: tb/tb_brdg_intrp_responder.sv
// Directed bench for brdg_intrp_responder: linear step sequence with immediate-assertion checks.
module tb_brdg_intrp_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  brdg_intrp_responder_if bus ();

  brdg_intrp_responder #(
    .PEND_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string name, input logic v, input logic [7:0] op,
                         input logic [15:0] tag, input logic [3:0] code);
    chk(name, {35'd0, bus.rsp_valid, bus.rsp_opcode, bus.rsp_afutag, bus.rsp_code},
        {35'd0, v, op, tag, code});
  endtask

  task automatic chk_idle(input string name);
    chk_rsp(name, 1'b0, 8'h00, 16'h0000, 4'h0);
  endtask

  task automatic send(input logic [7:0] op, input logic [15:0] tag, input logic [67:0] obj);
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = op;
    bus.cmd_afutag = tag;
    bus.cmd_obj    = obj;
    tick();
    bus.cmd_valid  = 1'b0;
    bus.cmd_opcode = 8'h00;
    bus.cmd_afutag = 16'h0000;
    bus.cmd_obj    = '0;
    $display("cmd op=%02h tag=%04h -> rsp v=%0d op=%02h tag=%04h code=%0h",
             op, tag, bus.rsp_valid, bus.rsp_opcode, bus.rsp_afutag, bus.rsp_code);
  endtask

  initial begin
    bus.cmd_valid      = 1'b0;
    bus.cmd_opcode     = 8'h00;
    bus.cmd_afutag     = 16'h0000;
    bus.cmd_obj        = '0;
    bus.host_accept_en = 1'b0;
    bus.force_retry    = 1'b0;
    bus.host_int_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk_idle("reset_rsp");
    chk("reset_host_valid", {63'd0, bus.host_int_valid}, 64'd0);
    chk("reset_host_src", bus.host_int_src, 64'd0);
    rst_n = 1'b1;
    tick();
    chk_idle("post_reset_rsp");

    // T1: direct delivery to the host slot
    bus.host_accept_en = 1'b1;
    send(8'h58, 16'hC000, 68'h1234);
    chk_rsp("t1_resp", 1'b1, 8'h0C, 16'hC000, 4'h0);
    chk("t1_host_valid", {63'd0, bus.host_int_valid}, 64'd1);
    chk("t1_host_src", bus.host_int_src, 64'h1234);
    bus.host_int_ready = 1'b1;
    tick();
    chk("t1_host_consumed", {63'd0, bus.host_int_valid}, 64'd0);
    chk_idle("t1_idle");
    bus.host_int_ready = 1'b0;

    // T2: fill the pending FIFO, overflow retries, then drain in order
    bus.host_accept_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send(8'h59, 16'(i), 68'h100 + 68'(i));
      chk_rsp("t2_pending", 1'b1, 8'h0C, 16'(i), 4'h4);
    end
    send(8'h59, 16'd5, 68'h105);
    chk_rsp("t2_full_retry", 1'b1, 8'h0C, 16'd5, 4'h2);
    chk("t2_slot_empty", {63'd0, bus.host_int_valid}, 64'd0);
    bus.host_accept_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_idle("t2_gap");
      tick();
      chk_rsp("t2_rdy", 1'b1, 8'h1A, 16'(i), 4'h0);
    end
    tick();
    chk_idle("t2_drained");

    // T3: slot busy pends the command; rdy after the host frees the slot; reissue succeeds
    send(8'h59, 16'h0010, 68'hAA);
    chk_rsp("t3_first_done", 1'b1, 8'h0C, 16'h0010, 4'h0);
    send(8'h59, 16'h0007, 68'hBB);
    chk_rsp("t3_pending", 1'b1, 8'h0C, 16'h0007, 4'h4);
    chk("t3_src_stable", bus.host_int_src, 64'hAA);
    tick();
    chk_idle("t3_wait");
    bus.host_int_ready = 1'b1;
    tick();
    bus.host_int_ready = 1'b0;
    chk("t3_slot_freed", {63'd0, bus.host_int_valid}, 64'd0);
    chk_idle("t3_free_cycle");
    tick();
    chk_idle("t3_enter_issue");
    tick();
    chk_rsp("t3_rdy", 1'b1, 8'h1A, 16'h0007, 4'h0);
    send(8'h59, 16'h0007, 68'hCC);
    chk_rsp("t3_reissue", 1'b1, 8'h0C, 16'h0007, 4'h0);
    chk("t3_reissue_src", bus.host_int_src, 64'hCC);
    bus.host_int_ready = 1'b1;
    tick();
    bus.host_int_ready = 1'b0;

    // T4: FAILED cases and force_retry on both resp and rdy
    send(8'h20, 16'h0021, 68'h1);
    chk_rsp("t4_bad_opcode", 1'b1, 8'h0C, 16'h0021, 4'hE);
    chk("t4_no_slot_load", {63'd0, bus.host_int_valid}, 64'd0);
    send(8'h58, 16'h0022, {4'h1, 64'h5});
    chk_rsp("t4_bad_obj", 1'b1, 8'h0C, 16'h0022, 4'hE);
    bus.force_retry = 1'b1;
    send(8'h5A, 16'h0023, 68'h6);
    chk_rsp("t4_force_resp", 1'b1, 8'h0C, 16'h0023, 4'h2);
    bus.force_retry    = 1'b0;
    bus.host_accept_en = 1'b0;
    send(8'h5B, 16'h0024, 68'h7);
    chk_rsp("t4_pend", 1'b1, 8'h0C, 16'h0024, 4'h4);
    bus.host_accept_en = 1'b1;
    bus.force_retry    = 1'b1;
    tick();
    chk_idle("t4_enter_issue");
    tick();
    chk_rsp("t4_force_rdy", 1'b1, 8'h1A, 16'h0024, 4'h2);
    bus.force_retry = 1'b0;
    chk("t4_slot_still_empty", {63'd0, bus.host_int_valid}, 64'd0);

    // T5: command collides with a ready-to-issue rdy; command wins, rdy follows
    bus.host_accept_en = 1'b0;
    send(8'h58, 16'h0030, 68'h30);
    chk_rsp("t5_pend", 1'b1, 8'h0C, 16'h0030, 4'h4);
    bus.host_accept_en = 1'b1;
    tick();
    chk_idle("t5_enter_issue");
    send(8'h58, 16'h0031, 68'h5555);
    chk_rsp("t5_cmd_wins", 1'b1, 8'h0C, 16'h0031, 4'h0);
    chk("t5_slot_loaded", bus.host_int_src, 64'h5555);
    tick();
    chk_rsp("t5_rdy_deferred", 1'b1, 8'h1A, 16'h0030, 4'h0);
    bus.host_int_ready = 1'b1;
    tick();
    bus.host_int_ready = 1'b0;
    chk_idle("t5_quiet");

    // T6: reset with three pended tags and a full slot
    send(8'h58, 16'h0040, 68'h99);
    chk_rsp("t6_slot_fill", 1'b1, 8'h0C, 16'h0040, 4'h0);
    bus.host_accept_en = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      send(8'h58, 16'h0040 + 16'(i), 68'h0);
      chk_rsp("t6_pend", 1'b1, 8'h0C, 16'h0040 + 16'(i), 4'h4);
    end
    rst_n = 1'b0;
    tick();
    chk_idle("t6_reset_rsp");
    chk("t6_reset_host_valid", {63'd0, bus.host_int_valid}, 64'd0);
    chk("t6_reset_host_src", bus.host_int_src, 64'd0);
    rst_n              = 1'b1;
    bus.host_accept_en = 1'b1;
    bus.host_int_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_idle("t6_no_rdy");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
